// File: rtl/shift_left_seq_pkg.sv
// Shared constants, state encodings and operand bundle for the sequential
// logical-left shifter.
package shift_left_seq_pkg;

    localparam int DATA_W     = 32;
    localparam int AMT_W      = 5;
    localparam int NUM_STAGES = 5;
    localparam int STAGE_W    = 3;

    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [AMT_W-1:0]  amt;
    } sll_req_t;

endpackage

// File: rtl/shift_left_seq_stage_mux.sv
// One radix-2 stage of a logical-left barrel shifter, selected by stage index;
// reports whether any nonzero bit falls off the top.
module sll_stage_mux
    import shift_left_seq_pkg::*;
(
    input  logic [DATA_W-1:0]  word,
    input  logic [STAGE_W-1:0] stage,
    input  logic               en,
    output logic [DATA_W-1:0]  shifted,
    output logic               spill
);

    logic [DATA_W-1:0] shl;
    logic              top_nz;

    always_comb begin
        shl    = word;
        top_nz = 1'b0;
        case (stage)
            3'd0: begin shl = {word[30:0], 1'b0};  top_nz = word[31];      end
            3'd1: begin shl = {word[29:0], 2'b0};  top_nz = |word[31:30];  end
            3'd2: begin shl = {word[27:0], 4'b0};  top_nz = |word[31:28];  end
            3'd3: begin shl = {word[23:0], 8'b0};  top_nz = |word[31:24];  end
            3'd4: begin shl = {word[15:0], 16'b0}; top_nz = |word[31:16];  end
            default: begin shl = word;             top_nz = 1'b0;          end
        endcase
    end

    assign shifted = en ? shl : word;
    assign spill   = en & top_nz;

endmodule

// File: rtl/shift_left_seq.sv
// Sequential 32-bit logical-left shifter: one reused stage mux walks the five
// distance bits MSB-first, so every operation costs exactly five busy cycles.
module shift_left_seq
    import shift_left_seq_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] in,
    input  logic [AMT_W-1:0]  shift_amt,
    output logic [DATA_W-1:0] out,
    output logic              ovf,
    output logic              busy,
    output logic              done
);

    logic [1:0]         state;
    sll_req_t           req_q;
    logic               acc;
    logic [STAGE_W-1:0] stage;

    logic [DATA_W-1:0]  mux_word;
    logic               mux_spill;
    logic               mux_en;

    // Distance bits are consumed from the captured copy so mid-operation input
    // changes cannot leak in.
    assign mux_en = req_q.amt[stage];

    sll_stage_mux u_stage (
        .word    (req_q.data),
        .stage   (stage),
        .en      (mux_en),
        .shifted (mux_word),
        .spill   (mux_spill)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            req_q <= '0;
            acc   <= 1'b0;
            stage <= '0;
            out   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        req_q.data <= in;
                        req_q.amt  <= shift_amt;
                        acc        <= 1'b0;
                        stage      <= LAST_STAGE;
                        state      <= ST_SHIFT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    req_q.data <= mux_word;
                    acc        <= acc | mux_spill;
                    if (stage == '0) begin
                        state <= ST_DONE;
                        out   <= mux_word;
                        ovf   <= acc | mux_spill;
                    end else begin
                        stage <= stage - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_shift_left_seq.sv
// Directed and random checks of shift_left_seq latency, results, hold
// behaviour, back-to-back issue and reset abort.
module tb_shift_left_seq;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] in;
    logic [4:0]  shift_amt;
    logic [31:0] out;
    logic        ovf;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;
    logic [31:0] last_out;

    shift_left_seq dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .in        (in),
        .shift_amt (shift_amt),
        .out       (out),
        .ovf       (ovf),
        .busy      (busy),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one op at a negedge, then check busy window, hold of old result,
    // the done cycle and the return to idle.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [4:0] s,
                          input logic [31:0] exp_out, input logic exp_ovf);
        @(negedge clock);
        start = 1'b1; in = a; shift_amt = s;
        @(posedge clock); #1;
        start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clock);
            in = $urandom; shift_amt = 5'($urandom);
            chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
            chk({tag, "_nodone"}, {31'b0, done}, 32'd0);
            chk({tag, "_hold"}, out, last_out);
        end
        @(negedge clock);
        chk({tag, "_done"}, {31'b0, done}, 32'd1);
        chk({tag, "_dbusy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_out"}, out, exp_out);
        chk({tag, "_ovf"}, {31'b0, ovf}, {31'b0, exp_ovf});
        last_out = exp_out;
        @(negedge clock);
        chk({tag, "_pulse"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        logic [63:0] wide;
        logic [31:0] ra;
        logic [4:0]  rs;

        reset = 1'b1; start = 1'b0; in = '0; shift_amt = '0;
        last_out = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_out", out, 32'd0);
        chk("rst_ovf", {31'b0, ovf}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        reset = 1'b0;

        run_op("amt31", 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0);
        run_op("f00f", 32'hF000_000F, 5'd4, 32'h0000_00F0, 1'b1);
        run_op("0fff", 32'h0FFF_FFFF, 5'd4, 32'hFFFF_FFF0, 1'b0);
        run_op("amt0", 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b0);
        run_op("amt31ovf", 32'h8000_0003, 5'd31, 32'h8000_0000, 1'b1);
        run_op("amt1", 32'h8000_0000, 5'd1, 32'h0000_0000, 1'b1);

        // Back-to-back with start held high; operands toggle while busy.
        @(negedge clock);
        start = 1'b1; in = 32'h1; shift_amt = 5'd1;
        @(posedge clock);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clock);
            chk("b2b_busy1", {31'b0, busy}, 32'd1);
            in = (i == 5) ? 32'h3 : $urandom;
            shift_amt = (i == 5) ? 5'd2 : 5'($urandom);
        end
        @(negedge clock);
        chk("b2b_done1", {31'b0, done}, 32'd1);
        chk("b2b_out1", out, 32'h2);
        for (int i = 7; i <= 11; i++) begin
            @(negedge clock);
            chk("b2b_busy2", {31'b0, busy}, 32'd1);
            chk("b2b_hold2", out, 32'h2);
            in = $urandom; shift_amt = 5'($urandom);
            if (i == 11) start = 1'b0;
        end
        @(negedge clock);
        chk("b2b_done2", {31'b0, done}, 32'd1);
        chk("b2b_out2", out, 32'hC);
        chk("b2b_ovf2", {31'b0, ovf}, 32'd0);
        @(negedge clock);
        chk("b2b_idle", {31'b0, busy | done}, 32'd0);
        last_out = 32'hC;

        // Reset in cycle 3 of an operation aborts it.
        @(negedge clock);
        start = 1'b1; in = 32'hFFFF_FFFF; shift_amt = 5'd3;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (2) @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_out", out, 32'd0);
        chk("abort_ovf", {31'b0, ovf}, 32'd0);
        start = 1'b1; in = 32'h5; shift_amt = 5'd2;
        @(negedge clock);
        chk("rst_pri_busy", {31'b0, busy}, 32'd0);
        reset = 1'b0; start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            chk("abort_quiet", {31'b0, busy | done}, 32'd0);
        end
        last_out = 32'd0;
        run_op("post_rst", 32'h0000_00FF, 5'd8, 32'h0000_FF00, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            ra = $urandom;
            rs = 5'($urandom);
            wide = {32'b0, ra} << rs;
            run_op("rand", ra, rs, wide[31:0], |wide[63:32]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
